// File: rtl/rv32i_mem_wb.sv
// Memory/writeback stage: takes one M-stage instruction at a time, runs the data-memory
// access over a req/gnt/rvalid bus and drives the register-file write port.
module rv32i_mem_wb #(
    parameter int DPW = 32,
    parameter int ADW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           validM,
    output logic           readyM,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [ADW-1:0] RdM,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DPW-1:0] dmem_addr,
    output logic [DPW-1:0] dmem_wdata,
    input  logic           dmem_gnt,
    input  logic           dmem_rvalid,
    input  logic [DPW-1:0] dmem_rdata,
    output logic           we,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3,
    output logic           misalign_err,
    output logic [31:0]    retired
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t         state_q;
    logic [DPW-1:0] addr_q;
    logic [DPW-1:0] wdata_q;
    logic           store_q;
    logic [ADW-1:0] rd_q;
    logic           regwrite_q;
    logic           we_q;
    logic [ADW-1:0] addr3_q;
    logic [DPW-1:0] wd3_q;
    logic           misalign_q;
    logic [31:0]    retired_q;
    logic [31:0]    retired_d;

    logic accept;
    logic isMemOp;
    logic misaligned;

    assign readyM     = (state_q == IDLE);
    assign accept     = validM & readyM;
    assign isMemOp    = memwriteM | resultsrcM;
    assign misaligned = (aluresultM[1:0] != 2'b00);
    assign retired_d  = retired_q + 32'd1;

    assign dmem_req     = (state_q == REQ);
    assign dmem_we      = store_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign we           = we_q;
    assign addr_3       = addr3_q;
    assign wd_3         = wd3_q;
    assign misalign_err = misalign_q;
    assign retired      = retired_q;

    // we and misalign_err are one-cycle pulses; they default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            we_q       <= 1'b0;
            addr3_q    <= '0;
            wd3_q      <= '0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
            if (accept) begin
                retired_q <= retired_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!isMemOp) begin
                            we_q    <= regwriteM & (RdM != '0);
                            addr3_q <= RdM;
                            wd3_q   <= aluresultM;
                        end else if (misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            // A combined store+load encoding is executed as a store.
                            addr_q     <= aluresultM;
                            wdata_q    <= Rd2M;
                            store_q    <= memwriteM;
                            rd_q       <= RdM;
                            regwrite_q <= regwriteM;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        state_q <= store_q ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        we_q    <= regwrite_q & (rd_q != '0);
                        addr3_q <= rd_q;
                        wd3_q   <= dmem_rdata;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_wb.sv
// Self-checking bench for rv32i_mem_wb: directed scenarios plus a randomized run whose
// expectations come from a per-instruction model of the stage's observable behaviour.
module tb_rv32i_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM, readyM;
    logic        regwriteM, resultsrcM, memwriteM;
    logic [31:0] aluresultM, Rd2M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        we;
    logic [4:0]  addr_3;
    logic [31:0] wd_3;
    logic        misalign_err;
    logic [31:0] retired;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] retExp  = 0;

    rv32i_mem_wb dut (
        .clk(clk), .rst(rst), .validM(validM), .readyM(readyM),
        .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
        .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .we(we), .addr_3(addr_3), .wd_3(wd_3), .misalign_err(misalign_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic v, input logic rw, input logic rs, input logic mw,
                            input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        validM = v; regwriteM = rw; resultsrcM = rs; memwriteM = mw;
        aluresultM = a; Rd2M = d; RdM = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setInstr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({readyM, dmem_req, dmem_we, we, misalign_err} !== 5'b10000) begin
            nFails++; $display("[TB] FAIL reset_ctrl: got %b want 10000", {readyM, dmem_req, dmem_we, we, misalign_err});
        end
        nChecks++;
        if ({dmem_addr, dmem_wdata, wd_3, retired} !== 128'h0 || addr_3 !== 5'd0) begin
            nFails++; $display("[TB] FAIL reset_data: addr %h wdata %h wd3 %h ret %h a3 %0d want all 0", dmem_addr, dmem_wdata, wd_3, retired, addr_3);
        end
        rst = 1'b0;
        retExp = 0;
    endtask

    task automatic test_alu();
        setInstr(1, 1, 0, 0, 32'h0000_1234, 32'h0, 5'd5);
        nChecks++;
        if (readyM !== 1'b1) begin nFails++; $display("[TB] FAIL alu_ready: got %b want 1", readyM); end
        tick();
        validM = 1'b0;
        retExp++;
        nChecks++;
        if (we !== 1'b1 || addr_3 !== 5'd5 || wd_3 !== 32'h1234) begin
            nFails++; $display("[TB] FAIL alu_wb: we %b a3 %0d wd3 %h want 1 5 00001234", we, addr_3, wd_3);
        end
        nChecks++;
        if (retired !== retExp) begin nFails++; $display("[TB] FAIL alu_retired: got %0d want %0d", retired, retExp); end
        tick();
        nChecks++;
        if (we !== 1'b0) begin nFails++; $display("[TB] FAIL alu_we_pulse: got %b want 0", we); end
    endtask

    task automatic test_store();
        setInstr(1, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3);
        tick();
        validM = 1'b0;
        retExp++;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if ({dmem_req, dmem_we, readyM, we} !== 4'b1100 || dmem_addr !== 32'h100 || dmem_wdata !== 32'hDEAD_BEEF) begin
                nFails++; $display("[TB] FAIL store_hold%0d: req/we/rdy/rfwe %b addr %h wdata %h want 1100 00000100 deadbeef",
                                   i, {dmem_req, dmem_we, readyM, we}, dmem_addr, dmem_wdata);
            end
            dmem_gnt = (i == 3);
            tick();
        end
        dmem_gnt = 1'b0;
        nChecks++;
        if ({readyM, dmem_req, we} !== 3'b100 || retired !== retExp) begin
            nFails++; $display("[TB] FAIL store_done: rdy/req/we %b ret %0d want 100 %0d", {readyM, dmem_req, we}, retired, retExp);
        end
    endtask

    task automatic test_load();
        setInstr(1, 1, 1, 0, 32'h0000_0040, 32'h0, 5'd7);
        tick();
        validM = 1'b0;
        retExp++;
        nChecks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin
            nFails++; $display("[TB] FAIL load_req: req %b we %b addr %h want 1 0 00000040", dmem_req, dmem_we, dmem_addr);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        tick();
        dmem_rvalid = 1'b0;
        nChecks++;
        if (dmem_req !== 1'b1 || we !== 1'b0) begin
            nFails++; $display("[TB] FAIL load_spurious: req %b we %b want 1 0", dmem_req, we);
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        nChecks++;
        if ({dmem_req, readyM, we} !== 3'b000) begin
            nFails++; $display("[TB] FAIL load_resp: req/rdy/we %b want 000", {dmem_req, readyM, we});
        end
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        nChecks++;
        if (we !== 1'b1 || addr_3 !== 5'd7 || wd_3 !== 32'hCAFE_F00D || readyM !== 1'b1) begin
            nFails++; $display("[TB] FAIL load_wb: we %b a3 %0d wd3 %h rdy %b want 1 7 cafef00d 1", we, addr_3, wd_3, readyM);
        end
        tick();
        nChecks++;
        if (we !== 1'b0) begin nFails++; $display("[TB] FAIL load_we_pulse: got %b want 0", we); end
    endtask

    task automatic test_misalign();
        setInstr(1, 1, 1, 0, 32'h0000_0102, 32'h0, 5'd9);
        tick();
        validM = 1'b0;
        retExp++;
        nChecks++;
        if ({dmem_req, misalign_err, we, readyM} !== 4'b0101 || retired !== retExp) begin
            nFails++; $display("[TB] FAIL misalign: req/err/we/rdy %b ret %0d want 0101 %0d", {dmem_req, misalign_err, we, readyM}, retired, retExp);
        end
        tick();
        nChecks++;
        if (misalign_err !== 1'b0 || dmem_req !== 1'b0) begin
            nFails++; $display("[TB] FAIL misalign_pulse: err %b req %b want 0 0", misalign_err, dmem_req);
        end
    endtask

    task automatic test_x0_and_reset();
        setInstr(1, 1, 0, 0, 32'h0000_ABCD, 32'h0, 5'd0);
        tick();
        validM = 1'b0;
        retExp++;
        nChecks++;
        if (we !== 1'b0) begin nFails++; $display("[TB] FAIL x0_we: got %b want 0", we); end
        setInstr(1, 1, 1, 0, 32'h0000_0080, 32'h0, 5'd12);
        tick();
        validM = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        nChecks++;
        if (readyM !== 1'b0 || dmem_req !== 1'b0) begin
            nFails++; $display("[TB] FAIL rst_pre_resp: rdy %b req %b want 0 0", readyM, dmem_req);
        end
        rst = 1'b1;
        #1;
        nChecks++;
        if ({readyM, dmem_req, dmem_we, we, misalign_err} !== 5'b10000 || retired !== 32'h0 || dmem_addr !== 32'h0 || addr_3 !== 5'd0) begin
            nFails++; $display("[TB] FAIL rst_async: ctrl %b ret %0d addr %h a3 %0d want 10000 0 0 0",
                               {readyM, dmem_req, dmem_we, we, misalign_err}, retired, dmem_addr, addr_3);
        end
        retExp = 0;
        tick();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (we !== 1'b0 || readyM !== 1'b1) begin
                nFails++; $display("[TB] FAIL rst_no_wb%0d: we %b rdy %b want 0 1", i, we, readyM);
            end
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic        rw, isMem, isStore, mis, expWe;
        logic [31:0] a, d, r;
        logic [4:0]  rdv;
        int          idle, dly;
        for (int n = 0; n < 300; n++) begin
            op  = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            rdv = 5'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d   = $urandom;
            r   = $urandom;
            isMem   = (op != 2'b00);
            isStore = op[0];
            mis     = isMem && (a[1:0] != 2'b00);
            idle    = $urandom_range(0, 2);
            if (idle > 0) begin
                validM = 1'b0;
                for (int i = 0; i < idle; i++) begin
                    tick();
                    nChecks++;
                    if (we !== 1'b0) begin nFails++; $display("[TB] FAIL rand_idle_we: n %0d got %b want 0", n, we); end
                end
            end
            setInstr(1, rw, op[1], op[0], a, d, rdv);
            nChecks++;
            if (readyM !== 1'b1) begin nFails++; $display("[TB] FAIL rand_ready: n %0d got %b want 1", n, readyM); end
            tick();
            retExp++;
            nChecks++;
            if (retired !== retExp) begin nFails++; $display("[TB] FAIL rand_retired: n %0d got %0d want %0d", n, retired, retExp); end
            if (!isMem) begin
                expWe = rw && (rdv != 5'd0);
                nChecks++;
                if (we !== expWe || misalign_err !== 1'b0) begin
                    nFails++; $display("[TB] FAIL rand_alu_we: n %0d we %b err %b want %b 0", n, we, misalign_err, expWe);
                end
                if (expWe) begin
                    nChecks++;
                    if (addr_3 !== rdv || wd_3 !== a) begin
                        nFails++; $display("[TB] FAIL rand_alu_data: n %0d a3 %0d wd3 %h want %0d %h", n, addr_3, wd_3, rdv, a);
                    end
                end
            end else if (mis) begin
                validM = 1'b0;
                nChecks++;
                if ({dmem_req, misalign_err, we} !== 3'b010) begin
                    nFails++; $display("[TB] FAIL rand_mis: n %0d req/err/we %b want 010", n, {dmem_req, misalign_err, we});
                end
            end else begin
                validM = 1'b0;
                dly = $urandom_range(0, 3);
                for (int i = 0; i <= dly; i++) begin
                    nChecks++;
                    if ({dmem_req, readyM, we} !== 3'b100 || dmem_we !== isStore || dmem_addr !== a || (isStore && dmem_wdata !== d)) begin
                        nFails++; $display("[TB] FAIL rand_req: n %0d req/rdy/we %b dwe %b addr %h wdata %h want 100 %b %h %h",
                                           n, {dmem_req, readyM, we}, dmem_we, dmem_addr, dmem_wdata, isStore, a, d);
                    end
                    dmem_gnt    = (i == dly);
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    dmem_rdata  = $urandom;
                    tick();
                end
                dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
                if (isStore) begin
                    nChecks++;
                    if ({dmem_req, readyM, we} !== 3'b010) begin
                        nFails++; $display("[TB] FAIL rand_store_done: n %0d req/rdy/we %b want 010", n, {dmem_req, readyM, we});
                    end
                end else begin
                    dly = $urandom_range(0, 3);
                    for (int i = 0; i <= dly; i++) begin
                        nChecks++;
                        if ({dmem_req, readyM, we} !== 3'b000) begin
                            nFails++; $display("[TB] FAIL rand_resp: n %0d req/rdy/we %b want 000", n, {dmem_req, readyM, we});
                        end
                        dmem_rvalid = (i == dly);
                        dmem_rdata  = (i == dly) ? r : $urandom;
                        tick();
                    end
                    dmem_rvalid = 1'b0;
                    expWe = rw && (rdv != 5'd0);
                    nChecks++;
                    if (we !== expWe || readyM !== 1'b1) begin
                        nFails++; $display("[TB] FAIL rand_load_we: n %0d we %b rdy %b want %b 1", n, we, readyM, expWe);
                    end
                    if (expWe) begin
                        nChecks++;
                        if (addr_3 !== rdv || wd_3 !== r) begin
                            nFails++; $display("[TB] FAIL rand_load_data: n %0d a3 %0d wd3 %h want %0d %h", n, addr_3, wd_3, rdv, r);
                        end
                    end
                end
            end
        end
        validM = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        nChecks++;
        if (retired !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL wrap_preload: got %h want ffffffff", retired); end
        setInstr(1, 1, 0, 0, 32'h0000_0077, 32'h0, 5'd1);
        tick();
        validM = 1'b0;
        nChecks++;
        if (retired !== 32'h0 || we !== 1'b1) begin
            nFails++; $display("[TB] FAIL wrap: ret %h we %b want 00000000 1", retired, we);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_misalign();
        test_x0_and_reset();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
